seg7_multi_digit_display: RTL and testbench
===========================================

// Module: seg7_multi_digit_display
// PURPOSE
//  Registered, parametrised multi-digit 7-segment driver. Converts an unsigned binary value to
//  NUM_DIGITS glyphs in decimal (sequential double-dabble) or hex mode, with optional leading-zero
//  blanking and overflow indication. Sits between datapath results (ALU, counters) and board
//  HEX displays. Replaces fixed 4-bit-to-two-digit decoding.
// PARAMETERS
//  NUM_DIGITS  4   number of 7-seg digits driven (1..8)
//  IN_WIDTH    14  width of binary input value (1..32)
//  ACTIVE_LOW  1   1: segment lit = 0 (board default); 0: segment lit = 1
// PORTS
//  clk        in   1             single clock, rising edge
//  rst_n      in   1             synchronous reset, active-low
//  load       in   1             request conversion of value; accepted only when busy=0
//  value      in   IN_WIDTH      unsigned binary input, sampled on accepted load
//  hex_mode   in   1             sampled with load: 1 = hex digits, 0 = decimal
//  blank_lz   in   1             sampled with load: 1 = blank leading zeros
//  busy       out  1             conversion in progress; load ignored
//  valid      out  1             one-cycle pulse: seg_out updated this cycle
//  overflow   out  1             last converted value did not fit NUM_DIGITS; held until next update
//  seg_out    out  7*NUM_DIGITS  digit k at [7k+6:7k], k=0 least significant; bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, busy=0, valid=0, overflow=0, seg_out = all blank.
//  Reset mid-conversion aborts; captured value discarded; same reset values.
//  FSM: IDLE -> (load) CONVERT -> ENCODE -> IDLE.
//   IDLE: load=1 captures value/hex_mode/blank_lz; busy=1 from next cycle.
//   CONVERT (decimal): one double-dabble shift per cycle (add-3 to any BCD nibble >=5, then shift);
//     exactly IN_WIDTH cycles. Hex: one cycle, nibbles taken directly from zero-extended value.
//   ENCODE: one cycle; glyphs computed and registered into seg_out, valid=1, busy=0 next cycle.
//  Latency load->valid: decimal IN_WIDTH+2 cycles, hex 3 cycles. Throughput: one conversion per
//   latency; a load in the same cycle valid is high is accepted (busy already 0).
//  load while busy=1: ignored, no queueing, no effect on conversion.
//  seg_out holds previous result during conversion (no flicker); changes only with valid.
//  Overflow: decimal if value >= 10**NUM_DIGITS; hex if value >= 16**NUM_DIGITS (check at capture).
//   On overflow all digits show dash (segment g only), overflow=1, blank_lz ignored.
//  Blanking: if blank_lz, digits above the most significant non-zero digit are blank; digit 0
//   always shown (value 0 shows single "0").
//  Glyphs (ACTIVE_LOW=1, gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110
//   F=0001110 dash=0111111 blank=1111111. ACTIVE_LOW=0: all bitwise inverted.
//  BCD register width 4*NUM_DIGITS; shift bits beyond it are discarded (overflow precomputed).
// STRUCTURE
//  Package seg7_pkg: glyph constants (GLYPH_0..GLYPH_F, GLYPH_DASH, GLYPH_BLANK, active-low form),
//   FSM state encoding.
//  Sub-module seg7_glyph_decoder: combinational 4-bit nibble + blank + dash -> 7 bits, applies
//   ACTIVE_LOW; instantiated NUM_DIGITS times via generate.
//  Top: FSM, capture registers, shift/BCD register, cycle counter, leading-zero scan, output regs.
// TESTING (NUM_DIGITS=4, IN_WIDTH=14, ACTIVE_LOW=1)
//  Reset then idle -> seg_out=28'hFFFFFFF, busy=0, valid=0, overflow=0.
//  load value=1234 dec -> valid pulse at cycle 16 after load; digits 3..0 = 1,2,3,4; busy high 15 cycles.
//  load 7 dec blank_lz=1 -> blank,blank,blank,"7"; load 0 blank_lz=1 -> blank x3,"0"; blank_lz=0 -> "0007".
//  load 16'h2AF hex -> "02AF" at cycle 3; overflow=0.
//  load 12000 dec -> four dashes (0111111 each), overflow=1; next load 5 clears overflow.
//  load during busy (value 99) ignored: first result unchanged; rst_n=0 mid-convert -> blank, busy=0, no valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit 7-segment driver: active-low glyph
// constants (bit order {g,f,e,d,c,b,a}), FSM states and small helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_ENCODE  = 2'd2
    } state_e;

    // Active-low glyphs: a 0 bit lights the segment.
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Active-low glyph for one hex nibble.
    function automatic logic [6:0] glyph_lookup(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

    // 10**n, used to precompute the decimal overflow threshold.
    function automatic logic [63:0] pow10_u64(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// One digit: nibble plus blank/dash overrides to 7 segment bits, with the
// board polarity applied. Dash wins over blank, blank wins over the nibble.
module seg7_glyph_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    logic [6:0] glyph_al;

    // Select the active-low glyph, then flip it for active-high boards.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        glyph_al = glyph_lookup(nibble_i);
        if (dash_i) begin
            glyph_al = GLYPH_DASH;
        end else if (blank_i) begin
            glyph_al = GLYPH_BLANK;
        end
        seg_o = ACTIVE_LOW ? glyph_al : ~glyph_al;
    end

endmodule

// File: rtl/seg7_multi_digit_display.sv
// Registered multi-digit 7-segment driver. A captured value is converted to
// BCD by sequential double-dabble (decimal) or taken as raw nibbles (hex),
// then encoded to glyphs with optional leading-zero blanking and overflow dashes.
module seg7_multi_digit_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IN_WIDTH   = 14,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [IN_WIDTH-1:0]     value,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    valid,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    localparam int                    BCD_W      = 4 * NUM_DIGITS;
    localparam int                    CNT_W      = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      CNT_INIT   = CNT_W'(IN_WIDTH - 1);
    localparam logic [63:0]           DEC_LIMIT  = pow10_u64(NUM_DIGITS);
    localparam logic [63:0]           HEX_LIMIT  = 64'd1 << BCD_W;
    localparam logic [6:0]            BLANK_OUT  = ACTIVE_LOW ? GLYPH_BLANK : ~GLYPH_BLANK;
    localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = {NUM_DIGITS{BLANK_OUT}};

    state_e                    state_q;
    logic [IN_WIDTH-1:0]       value_q;
    logic                      hex_q;
    logic                      blank_q;
    logic                      ovf_cap_q;
    logic [BCD_W-1:0]          bcd_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      busy_q;
    logic                      valid_q;
    logic                      overflow_q;
    logic [7*NUM_DIGITS-1:0]   seg_q;

    logic [BCD_W-1:0]          bcd_adj_d;
    logic [BCD_W-1:0]          bcd_shift_d;
    logic [BCD_W-1:0]          hex_bcd_d;
    logic [NUM_DIGITS-1:0]     digit_blank_d;
    logic [7*NUM_DIGITS-1:0]   glyph_d;
    logic                      seen_nz;

    // Hex nibbles straight from the captured value, zero-extended or truncated.
    if (IN_WIDTH >= BCD_W) begin : g_hex_trunc
        assign hex_bcd_d = value_q[BCD_W-1:0];
    end else begin : g_hex_ext
        assign hex_bcd_d = {{(BCD_W - IN_WIDTH){1'b0}}, value_q};
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next value bit.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            bcd_adj_d[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                             : bcd_q[4*k +: 4];
        end
        bcd_shift_d = (bcd_adj_d << 1) | BCD_W'(value_q[IN_WIDTH-1]);
    end

    // Leading-zero scan from the top digit down; digit 0 is never blanked.
    always_comb begin
        seen_nz       = 1'b0;
        digit_blank_d = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            digit_blank_d[k] = blank_q && !seen_nz && (k != 0);
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg7_glyph_decoder #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_dec (
            .nibble_i (bcd_q[4*k +: 4]),
            .blank_i  (digit_blank_d[k]),
            .dash_i   (ovf_cap_q),
            .seg_o    (glyph_d[7*k +: 7])
        );
    end

    // Control FSM with capture, conversion datapath and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            hex_q      <= 1'b0;
            blank_q    <= 1'b0;
            ovf_cap_q  <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            seg_q      <= SEG_RESET;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        value_q   <= value;
                        hex_q     <= hex_mode;
                        blank_q   <= blank_lz;
                        ovf_cap_q <= hex_mode ? (64'(value) >= HEX_LIMIT)
                                              : (64'(value) >= DEC_LIMIT);
                        bcd_q     <= '0;
                        cnt_q     <= CNT_INIT;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (hex_q) begin
                        bcd_q   <= hex_bcd_d;
                        state_q <= ST_ENCODE;
                    end else begin
                        bcd_q   <= bcd_shift_d;
                        value_q <= value_q << 1;
                        if (cnt_q == '0) begin
                            state_q <= ST_ENCODE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_ENCODE: begin
                    seg_q      <= glyph_d;
                    overflow_q <= ovf_cap_q;
                    valid_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_seg7_multi_digit_display.sv
// Self-checking bench: directed cases plus random conversions compared with
// an arithmetic reference (division/modulo per digit, direct glyph table).
module tb_seg7_multi_digit_display;

    localparam int ND = 4;
    localparam int IW = 14;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [27:0] SEG_BLANK = 28'hFFFFFFF;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [IW-1:0] value;
    logic          hex_mode;
    logic          blank_lz;
    logic          busy;
    logic          valid;
    logic          overflow;
    logic [27:0]   seg_out;

    int n_checks;
    int n_fails;

    logic [6:0]  glyph_tab [16];
    logic [27:0] exp_seg;
    logic        exp_ovf;

    seg7_multi_digit_display #(
        .NUM_DIGITS (ND),
        .IN_WIDTH   (IW),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow),
        .seg_out  (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: digits by repeated division, blanking by most significant non-zero digit.
    function automatic logic [27:0] model_seg(input int v, input bit hex, input bit blk,
                                              output bit ovf);
        logic [27:0] r;
        int base;
        int pw;
        int d [ND];
        int msd;
        base = hex ? 16 : 10;
        ovf  = v >= base * base * base * base;
        pw   = 1;
        msd  = 0;
        for (int k = 0; k < ND; k++) begin
            d[k] = (v / pw) % base;
            pw   = pw * base;
            if (d[k] != 0) msd = k;
        end
        for (int k = 0; k < ND; k++) begin
            if (ovf)                  r[7*k +: 7] = G_DASH;
            else if (blk && k > msd)  r[7*k +: 7] = G_BLANK;
            else                      r[7*k +: 7] = glyph_tab[d[k]];
        end
        return r;
    endfunction

    // Issue one load at a negedge and follow it cycle by cycle to the valid pulse.
    // Optionally pokes a load with value 99 while busy, which must be ignored.
    task automatic do_conv(input int v, input bit hex, input bit blk, input bit poke);
        logic [27:0] new_seg;
        bit          new_ovf;
        int          lat;
        new_seg  = model_seg(v, hex, blk, new_ovf);
        lat      = hex ? 3 : IW + 2;
        load     = 1'b1;
        value    = IW'(v);
        hex_mode = hex;
        blank_lz = blk;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            if (cyc < lat) begin
                check($sformatf("busy v=%0d c=%0d", v, cyc), 32'(busy), 32'd1);
                check($sformatf("novalid v=%0d c=%0d", v, cyc), 32'(valid), 32'd0);
                check($sformatf("hold seg v=%0d c=%0d", v, cyc), 32'(seg_out), 32'(exp_seg));
                check($sformatf("hold ovf v=%0d c=%0d", v, cyc), 32'(overflow), 32'(exp_ovf));
            end else begin
                check($sformatf("valid v=%0d", v), 32'(valid), 32'd1);
                check($sformatf("busy done v=%0d", v), 32'(busy), 32'd0);
                check($sformatf("seg v=%0d hex=%0d blk=%0d", v, hex, blk), 32'(seg_out), 32'(new_seg));
                check($sformatf("ovf v=%0d", v), 32'(overflow), 32'(new_ovf));
            end
            load = 1'b0;
            if (poke && cyc == 4) begin
                load     = 1'b1;
                value    = IW'(99);
                hex_mode = 1'b0;
                blank_lz = 1'b1;
            end
        end
        exp_seg = new_seg;
        exp_ovf = new_ovf;
    endtask

    task automatic idle_cycle();
        load = 1'b0;
        @(negedge clk);
        check("idle valid low", 32'(valid), 32'd0);
        check("idle busy low", 32'(busy), 32'd0);
        check("idle seg hold", 32'(seg_out), 32'(exp_seg));
    endtask

    initial begin
        int valid_seen;
        n_checks = 0;
        n_fails  = 0;
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        exp_seg  = SEG_BLANK;
        exp_ovf  = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset seg", 32'(seg_out), 32'(SEG_BLANK));
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);

        // Directed cases, with a busy-time load poke on the first one.
        do_conv(1234, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        do_conv(7, 1'b0, 1'b1, 1'b0);
        do_conv(0, 1'b0, 1'b1, 1'b0);
        do_conv(0, 1'b0, 1'b0, 1'b0);
        do_conv(16'h2AF, 1'b1, 1'b0, 1'b0);
        do_conv(12000, 1'b0, 1'b1, 1'b0);
        do_conv(5, 1'b0, 1'b0, 1'b0);
        do_conv(9999, 1'b0, 1'b1, 1'b0);
        do_conv(10000, 1'b0, 1'b0, 1'b0);
        do_conv(16'h3FFF, 1'b1, 1'b1, 1'b0);
        do_conv(16'h00F, 1'b1, 1'b1, 1'b0);
        idle_cycle();

        // Randomised conversions, back-to-back or with an idle gap.
        for (int i = 0; i < 40; i++) begin
            do_conv(int'($urandom_range(0, (1 << IW) - 1)), 1'($urandom), 1'($urandom),
                    1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset mid-conversion: abort to blank with no valid afterwards.
        load     = 1'b1;
        value    = IW'(4321);
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort seg", 32'(seg_out), 32'(SEG_BLANK));
        check("abort busy", 32'(busy), 32'd0);
        check("abort valid", 32'(valid), 32'd0);
        check("abort ovf", 32'(overflow), 32'd0);
        valid_seen = 0;
        for (int c = 0; c < IW + 6; c++) begin
            @(negedge clk);
            if (valid) valid_seen++;
        end
        check("no valid after abort", 32'(valid_seen), 32'd0);
        exp_seg = SEG_BLANK;
        exp_ovf = 1'b0;
        idle_cycle();

        // Normal operation after the abort.
        do_conv(42, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
